// File: rtl/midi_voice_allocator_pkg.sv
// Shared constants, FSM state and message-kind enums for the MIDI voice allocator.
// SUSTAIN_PEDAL_EN: when defined, CC 64 is classified as a sustain message.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CTRL     = 4'hB;

  localparam logic [6:0] CC_SUSTAIN       = 7'd64;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  localparam int unsigned OMNI_CH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SCAN,
    ST_COMMIT
  } state_t;

  typedef enum logic [2:0] {
    MSG_NONE,
    MSG_ON,
    MSG_OFF,
    MSG_ALLOFF,
    MSG_SUSTAIN
  } msg_t;

  function automatic msg_t classify(input logic [7:0] status,
                                    input logic [6:0] d1,
                                    input logic [6:0] d2,
                                    input logic       ch_ok);
    msg_t kind;
    kind = MSG_NONE;
    if (ch_ok) begin
      case (status[7:4])
        NOTE_ON:  kind = (d2 != 7'd0) ? MSG_ON : MSG_OFF;
        NOTE_OFF: kind = MSG_OFF;
        CTRL: begin
          if (d1 == CC_ALL_NOTES_OFF) kind = MSG_ALLOFF;
`ifdef SUSTAIN_PEDAL_EN
          else if (d1 == CC_SUSTAIN) kind = MSG_SUSTAIN;
`endif
        end
        default: kind = MSG_NONE;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/midi_voice_allocator_slot.sv
// One voice slot: gate, note, velocity, saturating age and (SUSTAIN_PEDAL_EN) held flag.
module midi_voice_slot #(
  parameter int unsigned AGE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             note_release,
  input  logic             age_inc,
  input  logic             clear,
`ifdef SUSTAIN_PEDAL_EN
  input  logic             hold,
  output logic             held,
`endif
  input  logic [6:0]       load_note,
  input  logic [6:0]       load_vel,
  output logic             gate,
  output logic             trig,
  output logic [6:0]       note,
  output logic [6:0]       vel,
  output logic [AGE_W-1:0] age
);

  always_ff @(posedge clk) begin
    if (reset) begin
      gate <= 1'b0;
      trig <= 1'b0;
      note <= '0;
      vel  <= '0;
      age  <= '0;
`ifdef SUSTAIN_PEDAL_EN
      held <= 1'b0;
`endif
    end else begin
      trig <= load;
      if (clear) begin
        gate <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
        held <= 1'b0;
`endif
      end else if (load) begin
        gate <= 1'b1;
        note <= load_note;
        vel  <= load_vel;
        age  <= '0;
`ifdef SUSTAIN_PEDAL_EN
        held <= 1'b0;
`endif
      end else begin
        if (note_release) begin
          gate <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
          held <= 1'b0;
        end else if (hold) begin
          held <= 1'b1;
`endif
        end
        if (age_inc && (age != '1)) age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: ready-edge capture, decode, per-slot scan, commit.
// SUSTAIN_PEDAL_EN: enables CC 64 sustain pedal with per-slot held flags.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned CHANNEL    = 0,
  parameter int unsigned AGE_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    midi_byte_ready,
  input  logic [7:0]              midi_byte0,
  input  logic [7:0]              midi_byte1,
  input  logic [7:0]              midi_byte2,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic                    busy,
  output logic                    msg_dropped
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);

  state_t           state;
  msg_t             kind;
  logic             ready_q;
  logic             rise;
  logic [7:0]       b0;
  logic [6:0]       b1;
  logic [6:0]       b2;
  logic             ch_ok;
  logic [IDX_W-1:0] scan_idx;
  logic             match_found;
  logic [IDX_W-1:0] match_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;
  logic [IDX_W-1:0] target;
  logic             unused_msb;

  logic [NUM_VOICES-1:0] s_gate, s_trig, s_load, s_rel, s_inc, s_clear;
  logic [6:0]            s_note [NUM_VOICES];
  logic [6:0]            s_vel  [NUM_VOICES];
  logic [AGE_W-1:0]      s_age  [NUM_VOICES];
`ifdef SUSTAIN_PEDAL_EN
  logic [NUM_VOICES-1:0] s_hold, s_held;
  logic                  pedal;
`endif

  assign rise       = midi_byte_ready & ~ready_q;
  assign busy       = (state != ST_IDLE);
  assign ch_ok      = (CHANNEL == OMNI_CH) || (b0[3:0] == 4'(CHANNEL));
  assign unused_msb = midi_byte1[7] ^ midi_byte2[7];
  assign target     = match_found ? match_idx : (free_found ? free_idx : old_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      kind        <= MSG_NONE;
      ready_q     <= 1'b0;
      msg_dropped <= 1'b0;
      b0          <= '0;
      b1          <= '0;
      b2          <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
`ifdef SUSTAIN_PEDAL_EN
      pedal       <= 1'b0;
`endif
    end else begin
      ready_q     <= midi_byte_ready;
      msg_dropped <= rise && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (rise) begin
            b0    <= midi_byte0;
            b1    <= midi_byte1[6:0];
            b2    <= midi_byte2[6:0];
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          kind        <= classify(b0, b1, b2, ch_ok);
          scan_idx    <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
          state       <= (classify(b0, b1, b2, ch_ok) == MSG_NONE) ? ST_IDLE : ST_SCAN;
        end
        ST_SCAN: begin
          if (!match_found && s_gate[scan_idx] && (s_note[scan_idx] == b1)) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          // Held slots keep their gate high, so they never look free here.
          if (!free_found && !s_gate[scan_idx]) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if ((scan_idx == '0) || (s_age[scan_idx] > old_age)) begin
            old_idx <= scan_idx;
            old_age <= s_age[scan_idx];
          end
          if (scan_idx == IDX_W'(NUM_VOICES - 1)) state <= ST_COMMIT;
          else scan_idx <= scan_idx + IDX_W'(1);
        end
        ST_COMMIT: begin
`ifdef SUSTAIN_PEDAL_EN
          if (kind == MSG_SUSTAIN) pedal <= b2[6];
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_load  = '0;
    s_rel   = '0;
    s_inc   = '0;
    s_clear = '0;
`ifdef SUSTAIN_PEDAL_EN
    s_hold  = '0;
`endif
    if (state == ST_COMMIT) begin
      case (kind)
        MSG_ON: begin
          s_load[target] = 1'b1;
          s_inc          = s_gate;
          s_inc[target]  = 1'b0;
        end
        MSG_OFF: begin
          if (match_found) begin
`ifdef SUSTAIN_PEDAL_EN
            if (pedal) s_hold[match_idx] = 1'b1;
            else       s_rel[match_idx]  = 1'b1;
`else
            s_rel[match_idx] = 1'b1;
`endif
          end
        end
        MSG_ALLOFF: s_clear = '1;
`ifdef SUSTAIN_PEDAL_EN
        MSG_SUSTAIN: if (pedal && !b2[6]) s_rel = s_held;
`endif
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    midi_voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk          (clk),
      .reset        (reset),
      .load         (s_load[i]),
      .note_release (s_rel[i]),
      .age_inc      (s_inc[i]),
      .clear        (s_clear[i]),
`ifdef SUSTAIN_PEDAL_EN
      .hold         (s_hold[i]),
      .held         (s_held[i]),
`endif
      .load_note    (b1),
      .load_vel     (b2),
      .gate         (s_gate[i]),
      .trig         (s_trig[i]),
      .note         (s_note[i]),
      .vel          (s_vel[i]),
      .age          (s_age[i])
    );
    assign voice_note[7*i +: 7] = s_note[i];
    assign voice_vel[7*i +: 7]  = s_vel[i];
  end

  assign voice_gate = s_gate;
  assign voice_trig = s_trig;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed self-checking bench for midi_voice_allocator (channel-0 and omni instances).
module tb_midi_voice_allocator;

  localparam int unsigned NV = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          midi_byte_ready = 1'b0;
  logic [7:0]    midi_byte0 = '0, midi_byte1 = '0, midi_byte2 = '0;

  logic [NV-1:0]   gate, trig, o_gate, o_trig;
  logic [7*NV-1:0] note, vel, o_note, o_vel;
  logic            busy, dropped, o_busy, o_dropped;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(0), .AGE_W(4)) dut (
    .clk(clk), .reset(reset), .midi_byte_ready(midi_byte_ready),
    .midi_byte0(midi_byte0), .midi_byte1(midi_byte1), .midi_byte2(midi_byte2),
    .voice_gate(gate), .voice_trig(trig), .voice_note(note), .voice_vel(vel),
    .busy(busy), .msg_dropped(dropped));

  midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(16), .AGE_W(4)) dut_omni (
    .clk(clk), .reset(reset), .midi_byte_ready(midi_byte_ready),
    .midi_byte0(midi_byte0), .midi_byte1(midi_byte1), .midi_byte2(midi_byte2),
    .voice_gate(o_gate), .voice_trig(o_trig), .voice_note(o_note), .voice_vel(o_vel),
    .busy(o_busy), .msg_dropped(o_dropped));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    midi_byte_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns 1 ns after the clock edge that ends COMMIT (edge + NV + 2 cycles).
  task automatic send(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    @(negedge clk);
    midi_byte0 = s; midi_byte1 = d1; midi_byte2 = d2;
    midi_byte_ready = 1'b1;
    repeat (2) @(negedge clk);
    midi_byte_ready = 1'b0;
    repeat (NV + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gate", 32'(gate), 0);
    check("rst_note", note, 0);
    check("rst_vel", vel, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_trig", 32'(trig), 0);
    @(negedge clk);
    reset = 1'b0;

    // Two ONs into free slots, then duplicate ON retriggers
    send(8'h90, 8'd60, 8'd100);
    check("on1_gate", 32'(gate), 32'b0001);
    check("on1_trig", 32'(trig), 32'b0001);
    check("on1_note0", 32'(note[6:0]), 60);
    check("on1_vel0", 32'(vel[6:0]), 100);
    @(posedge clk); #1;
    check("on1_trig_off", 32'(trig), 0);
    check("on1_busy", 32'(busy), 0);
    send(8'h90, 8'd64, 8'd90);
    check("on2_gate", 32'(gate), 32'b0011);
    check("on2_trig", 32'(trig), 32'b0010);
    check("on2_note1", 32'(note[13:7]), 64);
    check("on2_vel1", 32'(vel[13:7]), 90);
    send(8'h90, 8'd60, 8'd80);
    check("dup_gate", 32'(gate), 32'b0011);
    check("dup_trig", 32'(trig), 32'b0001);
    check("dup_vel0", 32'(vel[6:0]), 80);

    // Fill all slots then steal the oldest
    do_reset();
    for (int n = 60; n <= 63; n++) send(8'h90, 8'(n), 8'd100);
    check("fill_gate", 32'(gate), 32'b1111);
    send(8'h90, 8'd64, 8'd77);
    check("steal_gate", 32'(gate), 32'b1111);
    check("steal_trig", 32'(trig), 32'b0001);
    check("steal_note0", 32'(note[6:0]), 64);
    check("steal_vel0", 32'(vel[6:0]), 77);

    // OFF via vel 0, then OFF with no match
    send(8'h90, 8'd62, 8'd0);
    check("off_gate", 32'(gate), 32'b1011);
    check("off_note2", 32'(note[20:14]), 62);
    check("off_trig", 32'(trig), 0);
    send(8'h80, 8'd70, 8'd0);
    check("nomatch_gate", 32'(gate), 32'b1011);
    check("nomatch_note", note, {7'd63, 7'd62, 7'd61, 7'd64});

    // Second ready edge while busy is dropped; first message still lands in free slot 2
    @(negedge clk);
    midi_byte0 = 8'h90; midi_byte1 = 8'd70; midi_byte2 = 8'd50;
    midi_byte_ready = 1'b1;
    @(negedge clk);
    midi_byte_ready = 1'b0;
    @(negedge clk);
    midi_byte_ready = 1'b1;
    @(posedge clk); #1;
    check("drop_pulse", 32'(dropped), 1);
    check("drop_busy", 32'(busy), 1);
    @(posedge clk); #1;
    check("drop_pulse_off", 32'(dropped), 0);
    @(negedge clk);
    midi_byte_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drop_gate", 32'(gate), 32'b1111);
    check("drop_trig", 32'(trig), 32'b0100);
    check("drop_note2", 32'(note[20:14]), 70);
    check("drop_vel2", 32'(vel[20:14]), 50);

    // Channel filter vs omni, then all-notes-off
    do_reset();
    send(8'h91, 8'd60, 8'd100);
    check("ch1_gate", 32'(gate), 0);
    check("omni_gate", 32'(o_gate), 32'b0001);
    check("omni_note0", 32'(o_note[6:0]), 60);
    send(8'h90, 8'd61, 8'd10);
    check("ch0_gate", 32'(gate), 32'b0001);
    check("omni_gate2", 32'(o_gate), 32'b0011);
    send(8'hB0, 8'd123, 8'd0);
    check("alloff_gate", 32'(gate), 0);
    check("alloff_omni", 32'(o_gate), 0);
    check("alloff_note0", 32'(note[6:0]), 61);

    // Sustain pedal
    do_reset();
    send(8'hB0, 8'd64, 8'd127);
    send(8'h90, 8'd60, 8'd100);
    check("sus_on_gate", 32'(gate), 32'b0001);
    send(8'h80, 8'd60, 8'd0);
`ifdef SUSTAIN_PEDAL_EN
    check("sus_off_gate", 32'(gate), 32'b0001);
`else
    check("sus_off_gate", 32'(gate), 0);
`endif
    send(8'hB0, 8'd64, 8'd0);
    check("sus_rel_gate", 32'(gate), 0);

    // Reset during SCAN aborts the message
    send(8'h90, 8'd55, 8'd33);
    check("pre_abort_gate", 32'(gate), 32'b0001);
    @(negedge clk);
    midi_byte0 = 8'h90; midi_byte1 = 8'd50; midi_byte2 = 8'd40;
    midi_byte_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    midi_byte_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_gate", 32'(gate), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (NV + 4) @(posedge clk);
    #1;
    check("abort_after_gate", 32'(gate), 0);
    check("abort_after_trig", 32'(trig), 0);
    check("abort_after_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
